rx_bram_bank_scheduler: RTL and testbench

- Sequences a bank of NUM_BANKS parallel rx_BRAM_internal_controller instances in the rx chain.
- Accepts filtered samples, writes each one into a single bank chosen round-robin, and pulses new_sample_trig to all banks.
- Generates the timing for the MEMORY_LENGTH-cycle readout sweep that follows every sample: valid, index, last and bank tag, consumed by the downstream correlator.
- Detects samples that arrive before the current sweep has finished (overrun).

---
 rtl/rx_sched_pkg.sv | 24 ++
 rtl/rx_bank_rr_pointer.sv | 28 ++
 rtl/rx_bram_bank_scheduler.sv | 144 ++++++++++++++
 tb/tb_rx_bram_bank_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_sched_pkg.sv
// Shared definitions for the rx BRAM bank scheduler: FSM encoding, sample constants, bank decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rx_sched_pkg;

    localparam int SAMPLE_PERIOD = 512;  // nominal clocks between filtered samples
    localparam int SAMPLE_W      = 16;   // filtered sample width
    localparam int MAX_BANKS     = 8;    // widest one-hot the decode supports

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SWEEP = 2'd2
    } sched_state_t;

    // One-hot write enable for a bank index; callers truncate to their bank count.
    function automatic logic [MAX_BANKS-1:0] bank_onehot(input logic [2:0] idx);
        logic [MAX_BANKS-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/rx_bank_rr_pointer.sv
// Round-robin bank write pointer with wrap at NUM_BANKS-1 and a one-hot decode of the current bank.
// Latency: pointer advances on the edge where advance is high; bank_sel is combinational from wr_ptr.
// Backpressure: none; advance is honoured every cycle.
// Ports: crx_clk/rrx_rst clock and sync reset, advance step strobe, wr_ptr current bank, bank_sel one-hot of wr_ptr.
module rx_bank_rr_pointer
    import rx_sched_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = 3
) (
    input  logic                 crx_clk,
    input  logic                 rrx_rst,
    input  logic                 advance,
    output logic [BANK_W-1:0]    wr_ptr,
    output logic [NUM_BANKS-1:0] bank_sel
);

    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            wr_ptr <= '0;
        end else if (advance) begin
            wr_ptr <= (wr_ptr == BANK_W'(NUM_BANKS - 1)) ? '0 : wr_ptr + BANK_W'(1);
        end
    end

    assign bank_sel = NUM_BANKS'(bank_onehot(3'(wr_ptr)));

endmodule

// File: rtl/rx_bram_bank_scheduler.sv
// Writes each accepted sample to one BRAM bank round-robin, triggers all banks and times the readout sweep.
// Latency: trigger/write one cycle after accept; first sweep_valid RD_LATENCY cycles after the trigger.
// Backpressure: none; a sample arriving mid-sweep is still taken, aborts the sweep and sets sticky overrun.
// Ports: crx_clk/rrx_rst clock and sync reset, erx_en enable, sample_valid/sample_in sample strobe and data,
//        new_sample_trig/wr_en_RAM/data_in_RAM bank write side, sweep_valid/idx/last/bank readout timing, overrun error.
module rx_bram_bank_scheduler
    import rx_sched_pkg::*;
#(
    parameter int NUM_BANKS     = 4,
    parameter int MEMORY_LENGTH = 510,
    parameter int RD_LATENCY    = 2,
    parameter int BANK_W        = 3
) (
    input  logic                       crx_clk,
    input  logic                       rrx_rst,
    input  logic                       erx_en,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    output logic                       new_sample_trig,
    output logic [NUM_BANKS-1:0]       wr_en_RAM,
    output logic signed [SAMPLE_W-1:0] data_in_RAM,
    output logic                       sweep_valid,
    output logic [8:0]                 sweep_idx,
    output logic                       sweep_last,
    output logic [BANK_W-1:0]          sweep_bank,
    output logic                       overrun
);

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);
    localparam logic [8:0]       IDX_LAST = 9'(MEMORY_LENGTH - 1);

    // sweep_idx is 9 bits wide, so the sweep can never exceed one nominal sample period.
    generate
        if (MEMORY_LENGTH < 1 || MEMORY_LENGTH > SAMPLE_PERIOD) begin : g_bad_len
            $error("MEMORY_LENGTH must be in 1..%0d", SAMPLE_PERIOD);
        end
        if (NUM_BANKS < 2 || NUM_BANKS > MAX_BANKS || (1 << BANK_W) < NUM_BANKS) begin : g_bad_banks
            $error("NUM_BANKS must be 2..%0d and fit in BANK_W bits", MAX_BANKS);
        end
        if (RD_LATENCY < 1) begin : g_bad_lat
            $error("RD_LATENCY must be at least 1");
        end
    endgenerate

    sched_state_t          state_q, state_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [8:0]            idx_q, idx_d;
    logic                  accept;
    logic                  at_last;
    logic                  overrun_hit;
    logic [BANK_W-1:0]     wr_ptr;
    logic [NUM_BANKS-1:0]  bank_sel;

    assign accept  = sample_valid & erx_en;
    assign at_last = (state_q == ST_SWEEP) && (idx_q == IDX_LAST);
    // A sample landing on the final sweep cycle is the nominal back-to-back case, not an overrun.
    assign overrun_hit = accept && ((state_q == ST_WAIT) || ((state_q == ST_SWEEP) && !at_last));

    rx_bank_rr_pointer #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_rr_ptr (
        .crx_clk  (crx_clk),
        .rrx_rst  (rrx_rst),
        .advance  (accept),
        .wr_ptr   (wr_ptr),
        .bank_sel (bank_sel)
    );

    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_SWEEP: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 9'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        // Every accept restarts the latency wait for the new sample, abandoning any running sweep.
        if (accept) begin
            state_d = ST_WAIT;
            lat_d   = LAT_LOAD;
            idx_d   = '0;
        end
    end

    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            new_sample_trig <= 1'b0;
            wr_en_RAM       <= '0;
            data_in_RAM     <= '0;
            sweep_bank      <= '0;
            overrun         <= 1'b0;
        end else begin
            new_sample_trig <= accept;
            wr_en_RAM       <= accept ? bank_sel : '0;
            if (accept) begin
                data_in_RAM <= sample_in;
                sweep_bank  <= wr_ptr;
            end
            if (overrun_hit) begin
                overrun <= 1'b1;
            end
        end
    end

    assign sweep_valid = (state_q == ST_SWEEP);
    assign sweep_idx   = idx_q;
    assign sweep_last  = at_last;

endmodule

// File: tb/tb_rx_bram_bank_scheduler.sv
// Bench for rx_bram_bank_scheduler: per-cycle reference model plus table-driven and directed sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_bram_bank_scheduler;

    localparam int NB = 4;
    localparam int ML = 510;
    localparam int RD = 2;
    localparam int BW = 3;

    logic               crx_clk = 1'b0;
    logic               rrx_rst = 1'b1;
    logic               erx_en = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               new_sample_trig;
    logic [NB-1:0]      wr_en_RAM;
    logic signed [15:0] data_in_RAM;
    logic               sweep_valid;
    logic [8:0]         sweep_idx;
    logic               sweep_last;
    logic [BW-1:0]      sweep_bank;
    logic               overrun;

    always #5 crx_clk = ~crx_clk;

    rx_bram_bank_scheduler #(
        .NUM_BANKS     (NB),
        .MEMORY_LENGTH (ML),
        .RD_LATENCY    (RD),
        .BANK_W        (BW)
    ) dut (
        .crx_clk         (crx_clk),
        .rrx_rst         (rrx_rst),
        .erx_en          (erx_en),
        .sample_valid    (sample_valid),
        .sample_in       (sample_in),
        .new_sample_trig (new_sample_trig),
        .wr_en_RAM       (wr_en_RAM),
        .data_in_RAM     (data_in_RAM),
        .sweep_valid     (sweep_valid),
        .sweep_idx       (sweep_idx),
        .sweep_last      (sweep_last),
        .sweep_bank      (sweep_bank),
        .overrun         (overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: remembers only when the last accepted sample was triggered and derives
    // every output from the elapsed cycle count.
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          has_acc = 0;
    int          bank_m = 0;
    int          sb_m = 0;
    bit          ovr_m = 0;
    logic [15:0] data_m = '0;

    function automatic void model_step(input bit rst, input bit v, input bit en, input logic [15:0] d);
        cyc++;
        if (rst) begin
            has_acc = 0;
            bank_m  = 0;
            sb_m    = 0;
            ovr_m   = 0;
            data_m  = '0;
        end else if (v && en) begin
            if (has_acc && (cyc - acc_cyc) < RD + ML) ovr_m = 1;
            sb_m    = bank_m;
            bank_m  = (bank_m + 1) % NB;
            acc_cyc = cyc;
            has_acc = 1;
            data_m  = d;
        end
    endfunction

    task automatic check_model();
        int k;
        bit trig;
        bit vld;
        k    = cyc - acc_cyc - RD;
        trig = has_acc && (cyc == acc_cyc);
        vld  = has_acc && (k >= 0) && (k < ML);
        chk("mdl_trig",    32'(new_sample_trig), 32'(trig));
        chk("mdl_wr_en",   32'(wr_en_RAM),       trig ? (32'd1 << sb_m) : 32'd0);
        chk("mdl_data",    {16'h0, data_in_RAM}, {16'h0, data_m});
        chk("mdl_valid",   32'(sweep_valid),     32'(vld));
        chk("mdl_idx",     32'(sweep_idx),       vld ? 32'(k) : 32'd0);
        chk("mdl_last",    32'(sweep_last),      32'(vld && (k == ML - 1)));
        chk("mdl_bank",    32'(sweep_bank),      32'(sb_m));
        chk("mdl_overrun", 32'(overrun),         32'(ovr_m));
    endtask

    // One clock: drive inputs away from the active edge, advance the model, check at the falling edge.
    task automatic tick(input bit rst, input bit v, input bit en, input logic [15:0] d);
        rrx_rst      = rst;
        sample_valid = v;
        erx_en       = en;
        sample_in    = d;
        @(posedge crx_clk);
        model_step(rst, v, en, d);
        @(negedge crx_clk);
        check_model();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_trig"},  32'(new_sample_trig), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en_RAM),       32'd0);
        chk({tag, "_data"},  {16'h0, data_in_RAM}, 32'd0);
        chk({tag, "_valid"}, 32'(sweep_valid),     32'd0);
        chk({tag, "_idx"},   32'(sweep_idx),       32'd0);
        chk({tag, "_last"},  32'(sweep_last),      32'd0);
        chk({tag, "_bank"},  32'(sweep_bank),      32'd0);
        chk({tag, "_ovr"},   32'(overrun),         32'd0);
    endtask

    typedef struct {
        int          gap;
        logic [15:0] din;
        logic [3:0]  exp_wr;
        logic        exp_ovr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int nvalid;
        int nlast;

        tbl[0] = '{gap: 10,  din: 16'h1234, exp_wr: 4'b0001, exp_ovr: 1'b0};
        tbl[1] = '{gap: 512, din: 16'h8000, exp_wr: 4'b0010, exp_ovr: 1'b0};
        tbl[2] = '{gap: 512, din: 16'h7fff, exp_wr: 4'b0100, exp_ovr: 1'b0};
        tbl[3] = '{gap: 512, din: 16'h0001, exp_wr: 4'b1000, exp_ovr: 1'b0};
        tbl[4] = '{gap: 512, din: 16'hffff, exp_wr: 4'b0001, exp_ovr: 1'b0};

        // Reset state.
        repeat (3) tick(1, 0, 0, 16'h0);
        check_all_zero("reset");

        // Nominal-rate samples, including the legal accept on the final sweep cycle.
        for (int i = 0; i < 5; i++) begin
            repeat (tbl[i].gap - 1) tick(0, 0, 1, 16'h0);
            tick(0, 1, 1, tbl[i].din);
            chk("tbl_trig",  32'(new_sample_trig), 32'd1);
            chk("tbl_wr_en", 32'(wr_en_RAM),       32'(tbl[i].exp_wr));
            chk("tbl_data",  {16'h0, data_in_RAM}, {16'h0, tbl[i].din});
            chk("tbl_ovr",   32'(overrun),         32'(tbl[i].exp_ovr));
        end
        nvalid = 0;
        nlast  = 0;
        for (int i = 0; i < 515; i++) begin
            tick(0, 0, 1, 16'h0);
            if (i == 1) chk("sweep_first_idx", 32'(sweep_idx), 32'd0);
            nvalid += int'(sweep_valid);
            nlast  += int'(sweep_last);
        end
        chk("sweep_len",      32'(nvalid), 32'(ML));
        chk("sweep_last_cnt", 32'(nlast),  32'd1);

        // Overrun: second sample 100 clocks after the first.
        repeat (2) tick(1, 0, 0, 16'h0);
        tick(0, 1, 1, 16'h0a0a);
        repeat (99) tick(0, 0, 1, 16'h0);
        tick(0, 1, 1, 16'h0b0b);
        chk("ovr_wr_en", 32'(wr_en_RAM), 32'b0010);
        chk("ovr_flag",  32'(overrun),   32'd1);
        nlast = 0;
        for (int i = 0; i < 515; i++) begin
            tick(0, 0, 1, 16'h0);
            if (i == 1) chk("ovr_restart_valid", 32'(sweep_valid), 32'd1);
            nlast += int'(sweep_last);
        end
        chk("ovr_last_cnt", 32'(nlast),   32'd1);
        chk("ovr_sticky",   32'(overrun), 32'd1);

        // erx_en dropped mid-sweep: no writes, sweep completes, pointer holds.
        repeat (2) tick(1, 0, 0, 16'h0);
        tick(0, 1, 1, 16'h1111);
        nvalid = 0;
        for (int i = 0; i < 100; i++) begin
            tick(0, 0, 1, 16'h0);
            nvalid += int'(sweep_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 16'h2222);
            chk("en_lo_trig",  32'(new_sample_trig), 32'd0);
            chk("en_lo_wr_en", 32'(wr_en_RAM),       32'd0);
            nvalid += int'(sweep_valid);
        end
        for (int i = 0; i < 420; i++) begin
            tick(0, 0, 0, 16'h0);
            nvalid += int'(sweep_valid);
        end
        chk("en_lo_sweep_len", 32'(nvalid), 32'(ML));
        tick(0, 1, 1, 16'h3333);
        chk("en_back_wr_en", 32'(wr_en_RAM), 32'b0010);

        // Reset in the middle of a sweep.
        repeat (2) tick(1, 0, 0, 16'h0);
        tick(0, 1, 1, 16'h4444);
        repeat (202) tick(0, 0, 1, 16'h0);
        chk("mid_idx", 32'(sweep_idx), 32'd200);
        tick(1, 0, 1, 16'h0);
        check_all_zero("mid_rst");
        tick(0, 0, 1, 16'h0);
        tick(0, 1, 1, 16'h5555);
        chk("post_rst_wr_en", 32'(wr_en_RAM),  32'b0001);
        chk("post_rst_bank",  32'(sweep_bank), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit r;
            bit v;
            r = ($urandom_range(0, 1999) == 0);
            v = ($urandom_range(0, 299) == 0) || (($urandom_range(0, 7) == 0) && sample_valid);
            if ($urandom_range(0, 199) == 0) erx_en = ~erx_en;
            tick(r, v, erx_en, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
